// File: rtl/sim_dmi_sequencer.sv
// sim_dmi_sequencer: DMI master for simulation and FPGA harnesses.
//
// Host commands are queued in a small FIFO and issued one at a time as DMI requests. Busy
// responses are reissued after a fixed backoff until a retry limit is reached. The response
// wait is bounded by an optional timeout. Each non-exit command returns exactly one result.
// Exit commands update a sticky exit code and generate no DMI traffic.
//
// Ports:
//   clk, reset_n                       clock, asynchronous active-low reset
//   cmd_valid/cmd_ready                host command handshake (ready = FIFO not full)
//   cmd_addr/cmd_op/cmd_data           command: op 0 nop, 1 read, 2 write, 3 exit
//   res_valid/res_ready                result handshake
//   res_resp/res_data                  result: 0 ok, 2 failed/timeout, 3 busy
//   debug_req_*                        DMI request channel
//   debug_resp_*                       DMI response channel
//   exit                               0 while running, {code[30:0],1} after an exit command
//   timeout_err                        sticky flag, set when any command timed out
module sim_dmi_sequencer #(
  parameter int unsigned ADDR_BITS      = 7,
  parameter int unsigned DATA_BITS      = 32,
  parameter int unsigned CMD_DEPTH      = 4,
  parameter int unsigned MAX_RETRY      = 15,
  parameter int unsigned BACKOFF_CYCLES = 8,
  parameter int unsigned TIMEOUT        = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic [1:0]           cmd_op,
  input  logic [DATA_BITS-1:0] cmd_data,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [1:0]           res_resp,
  output logic [DATA_BITS-1:0] res_data,
  output logic                 debug_req_valid,
  input  logic                 debug_req_ready,
  output logic [ADDR_BITS-1:0] debug_req_bits_addr,
  output logic [1:0]           debug_req_bits_op,
  output logic [DATA_BITS-1:0] debug_req_bits_data,
  input  logic                 debug_resp_valid,
  output logic                 debug_resp_ready,
  input  logic [1:0]           debug_resp_bits_resp,
  input  logic [DATA_BITS-1:0] debug_resp_bits_data,
  output logic [31:0]          exit,
  output logic                 timeout_err
);

  localparam int unsigned PtrW   = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned BoffW  = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;
  localparam int unsigned TmoW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned EntryW = ADDR_BITS + 2 + DATA_BITS;

  typedef enum logic [2:0] {StIdle, StReq, StWait, StBackoff, StReport} state_e;

  state_e state_q, state_d;

  // Command FIFO
  logic [EntryW-1:0]    fifo_q [CMD_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]        count_q;
  logic                 init_q;
  logic                 full, empty, push, pop, exit_pop;
  logic [ADDR_BITS-1:0] head_addr;
  logic [1:0]           head_op;
  logic [DATA_BITS-1:0] head_data;

  // Sequencer state
  logic [RetryW-1:0]    retry_q, retry_d;
  logic [TmoW-1:0]      tmo_q, tmo_d;
  logic [BoffW-1:0]     boff_q, boff_d;
  logic [1:0]           res_resp_q, res_resp_d;
  logic [DATA_BITS-1:0] res_data_q, res_data_d;
  logic [31:0]          exit_q, exit_d;
  logic                 tmo_err_q, tmo_err_d;

  assign {head_addr, head_op, head_data} = fifo_q[rd_ptr_q];

  assign full  = (count_q == (PtrW + 1)'(CMD_DEPTH));
  assign empty = (count_q == '0);

  // init_q holds cmd_ready low for the first cycle after reset release.
  assign cmd_ready = init_q & ~full;
  assign push      = cmd_valid & cmd_ready;
  assign pop       = exit_pop | ((state_q == StReport) & res_ready);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= {cmd_addr, cmd_op, cmd_data};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      init_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      init_q <= 1'b1;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      retry_q    <= '0;
      tmo_q      <= '0;
      boff_q     <= '0;
      res_resp_q <= '0;
      res_data_q <= '0;
      exit_q     <= '0;
      tmo_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      retry_q    <= retry_d;
      tmo_q      <= tmo_d;
      boff_q     <= boff_d;
      res_resp_q <= res_resp_d;
      res_data_q <= res_data_d;
      exit_q     <= exit_d;
      tmo_err_q  <= tmo_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    retry_d    = retry_q;
    tmo_d      = tmo_q;
    boff_d     = boff_q;
    res_resp_d = res_resp_q;
    res_data_d = res_data_q;
    exit_d     = exit_q;
    tmo_err_d  = tmo_err_q;
    exit_pop   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          if (head_op == 2'd3) begin
            exit_d   = {head_data[30:0], 1'b1};
            exit_pop = 1'b1;
          end else begin
            retry_d = '0;
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (debug_req_ready) begin
          tmo_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (debug_resp_valid) begin
          if ((debug_resp_bits_resp == 2'd3) && (retry_q < RetryW'(MAX_RETRY))) begin
            retry_d = retry_q + 1'b1;
            boff_d  = '0;
            state_d = StBackoff;
          end else begin
            res_resp_d = debug_resp_bits_resp;
            res_data_d = debug_resp_bits_data;
            state_d    = StReport;
          end
        end else if ((TIMEOUT != 0) && (tmo_q == TmoW'(TIMEOUT - 1))) begin
          res_resp_d = 2'd2;
          res_data_d = '0;
          tmo_err_d  = 1'b1;
          state_d    = StReport;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StBackoff: begin
        if (boff_q == BoffW'(BACKOFF_CYCLES - 1)) begin
          state_d = StReq;
        end else begin
          boff_d = boff_q + 1'b1;
        end
      end
      StReport: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign debug_req_valid     = (state_q == StReq);
  assign debug_req_bits_addr = debug_req_valid ? head_addr : '0;
  assign debug_req_bits_op   = debug_req_valid ? head_op : '0;
  assign debug_req_bits_data = debug_req_valid ? head_data : '0;

  // Accepting responses in IDLE drains late responses after a timeout; they are discarded.
  assign debug_resp_ready = init_q & ((state_q == StIdle) | (state_q == StWait));

  assign res_valid   = (state_q == StReport);
  assign res_resp    = res_resp_q;
  assign res_data    = res_data_q;
  assign exit        = exit_q;
  assign timeout_err = tmo_err_q;

endmodule

// File: tb/tb_sim_dmi_sequencer.sv
// Bench for sim_dmi_sequencer: directed commands against a scripted DMI slave. Expected results
// are queued when commands are issued; a monitor pops and compares on each result handshake.
module tb_sim_dmi_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [6:0]  cmd_addr;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_data;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_resp;
  logic [31:0] res_data;
  logic        debug_req_valid;
  logic        debug_req_ready;
  logic [6:0]  debug_req_bits_addr;
  logic [1:0]  debug_req_bits_op;
  logic [31:0] debug_req_bits_data;
  logic        debug_resp_valid;
  logic        debug_resp_ready;
  logic [1:0]  debug_resp_bits_resp;
  logic [31:0] debug_resp_bits_data;
  logic [31:0] exit;
  logic        timeout_err;

  always #5 clk = ~clk;

  sim_dmi_sequencer #(
    .ADDR_BITS     (7),
    .DATA_BITS     (32),
    .CMD_DEPTH     (4),
    .MAX_RETRY     (2),
    .BACKOFF_CYCLES(8),
    .TIMEOUT       (16)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_addr            (cmd_addr),
    .cmd_op              (cmd_op),
    .cmd_data            (cmd_data),
    .res_valid           (res_valid),
    .res_ready           (res_ready),
    .res_resp            (res_resp),
    .res_data            (res_data),
    .debug_req_valid     (debug_req_valid),
    .debug_req_ready     (debug_req_ready),
    .debug_req_bits_addr (debug_req_bits_addr),
    .debug_req_bits_op   (debug_req_bits_op),
    .debug_req_bits_data (debug_req_bits_data),
    .debug_resp_valid    (debug_resp_valid),
    .debug_resp_ready    (debug_resp_ready),
    .debug_resp_bits_resp(debug_resp_bits_resp),
    .debug_resp_bits_data(debug_resp_bits_data),
    .exit                (exit),
    .timeout_err         (timeout_err)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // ---------------- scripted DMI slave (drives at negedge) ----------------
  bit          req_ready_en = 1'b1;
  int          resp_delay   = 1;
  bit          addr_mode    = 1'b0;
  logic [31:0] slave_data   = 32'h0;
  logic [1:0]  resp_script[$];
  int          req_count    = 0;
  int          req_cyc[$];
  logic [6:0]  last_addr;
  logic [1:0]  last_op;
  logic [31:0] last_data;
  int          fire_count   = 0;
  int          fire_cyc     = 0;
  bit          pending      = 1'b0;
  bit          fired        = 1'b0;
  int          cd           = 0;
  logic [1:0]  p_resp;
  logic [31:0] p_data;

  always @(negedge clk) begin
    if (!reset_n) begin
      pending          = 1'b0;
      fired            = 1'b0;
      debug_resp_valid = 1'b0;
      debug_req_ready  = 1'b0;
    end else begin
      if (fired) begin
        debug_resp_valid = 1'b0;
        fired            = 1'b0;
      end
      if (pending) begin
        cd--;
        if (cd == 0) begin
          pending              = 1'b0;
          debug_resp_valid     = 1'b1;
          debug_resp_bits_resp = p_resp;
          debug_resp_bits_data = p_data;
        end
      end
      debug_req_ready = req_ready_en;
      if (debug_req_valid && debug_req_ready) begin
        req_count++;
        req_cyc.push_back(cyc);
        last_addr = debug_req_bits_addr;
        last_op   = debug_req_bits_op;
        last_data = debug_req_bits_data;
        pending   = 1'b1;
        cd        = resp_delay;
        if (resp_script.size() > 0) p_resp = resp_script.pop_front();
        else p_resp = 2'd0;
        if (addr_mode) p_data = 32'hA000_0000 | {25'h0, debug_req_bits_addr};
        else p_data = slave_data;
      end
      if (debug_resp_valid && debug_resp_ready) begin
        fired = 1'b1;
        fire_count++;
        fire_cyc = cyc;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic [33:0] sb[$];
  logic [33:0] exp_e;

  always @(negedge clk) begin
    if (reset_n && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got resp=%0d data=0x%08h expected none",
                 res_resp, res_data);
      end else begin
        exp_e = sb.pop_front();
        check("res_resp", 32'(res_resp), 32'(exp_e[33:32]));
        check("res_data", res_data, exp_e[31:0]);
      end
    end
  end

  // ---------------- stimulus helpers (all return at posedge + #1) ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                          output int pcyc);
    int budget;
    budget    = 400;
    pcyc      = -1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    while (budget > 0) begin
      @(negedge clk);
      if (cmd_ready) begin
        pcyc = cyc;
        break;
      end
      budget--;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (pcyc < 0) fail_now("push_cmd");
  endtask

  task automatic wait_req(input int target);
    int budget;
    budget = 200;
    while (req_count < target && budget > 0) begin
      tick(1);
      budget--;
    end
    if (req_count < target) fail_now("wait_req");
  endtask

  task automatic wait_sb_empty();
    int budget;
    budget = 600;
    while (sb.size() != 0 && budget > 0) begin
      tick(1);
      budget--;
    end
    if (sb.size() != 0) fail_now("wait_result");
  endtask

  task automatic wait_res_valid(output int rcyc);
    int budget;
    budget = 200;
    rcyc   = -1;
    while (budget > 0) begin
      @(negedge clk);
      if (res_valid) begin
        rcyc = cyc;
        break;
      end
      budget--;
    end
    @(posedge clk);
    #1;
    if (rcyc < 0) fail_now("wait_res_valid");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int pc;
    int r0;
    int rc;
    int f0;
    int budget;

    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_op    = '0;
    cmd_data  = '0;
    res_ready = 1'b1;
    debug_req_ready      = 1'b0;
    debug_resp_valid     = 1'b0;
    debug_resp_bits_resp = '0;
    debug_resp_bits_data = '0;
    tick(3);

    check("rst_cmd_ready", 32'(cmd_ready), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_req_valid", 32'(debug_req_valid), 0);
    check("rst_resp_ready", 32'(debug_resp_ready), 0);
    check("rst_exit", exit, 0);
    check("rst_timeout_err", 32'(timeout_err), 0);

    reset_n = 1'b1;
    @(negedge clk);
    check("cmd_ready_cycle0", 32'(cmd_ready), 0);
    @(negedge clk);
    check("cmd_ready_cycle1", 32'(cmd_ready), 1);
    tick(1);

    // Write 0x10 <- 1, result held until res_ready
    res_ready  = 1'b0;
    slave_data = 32'h0;
    sb.push_back({2'd0, 32'h0});
    r0 = req_count;
    push_cmd(2'd2, 7'h10, 32'h1, pc);
    wait_req(r0 + 1);
    if (req_count > r0) begin
      check("wr_req_latency", req_cyc[r0], pc + 2);
      check("wr_req_addr", 32'(last_addr), 32'h10);
      check("wr_req_op", 32'(last_op), 2);
      check("wr_req_data", last_data, 32'h1);
    end
    wait_res_valid(rc);
    check("wr_res_latency", rc, fire_cyc + 1);
    tick(5);
    check("wr_res_held", 32'(res_valid), 1);
    check("wr_res_held_resp", 32'(res_resp), 0);
    res_ready = 1'b1;
    wait_sb_empty();

    // Read with two busy responses then ok
    resp_script = '{2'd3, 2'd3, 2'd0};
    slave_data  = 32'hDEADBEEF;
    sb.push_back({2'd0, 32'hDEADBEEF});
    r0 = req_count;
    push_cmd(2'd1, 7'h11, 32'h0, pc);
    wait_sb_empty();
    check("busy_req_count", req_count - r0, 3);
    if (req_count >= r0 + 3) begin
      check("busy_gap1", req_cyc[r0 + 1] - req_cyc[r0], 10);
      check("busy_gap2", req_cyc[r0 + 2] - req_cyc[r0 + 1], 10);
    end

    // Always busy: retries exhausted after 3 requests
    resp_script = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
    slave_data  = 32'h0000_1234;
    sb.push_back({2'd3, 32'h0000_1234});
    r0 = req_count;
    push_cmd(2'd1, 7'h12, 32'h0, pc);
    wait_sb_empty();
    tick(12);
    check("exhaust_req_count", req_count - r0, 3);
    resp_script.delete();

    // Timeout, then a late response that must be dropped
    check("tmo_err_before", 32'(timeout_err), 0);
    resp_delay = 21;
    slave_data = 32'h0BAD_0BAD;
    sb.push_back({2'd2, 32'h0});
    r0 = req_count;
    f0 = fire_count;
    push_cmd(2'd1, 7'h13, 32'h0, pc);
    wait_res_valid(rc);
    if (req_count > r0) check("tmo_res_cycle", rc, req_cyc[r0] + 17);
    wait_sb_empty();
    check("tmo_err_set", 32'(timeout_err), 1);
    budget = 40;
    while (fire_count == f0 && budget > 0) begin
      tick(1);
      budget--;
    end
    check("late_resp_accepted", fire_count - f0, 1);
    resp_delay = 1;
    slave_data = 32'hCAFE_0001;
    sb.push_back({2'd0, 32'hCAFE_0001});
    push_cmd(2'd1, 7'h14, 32'h0, pc);
    wait_sb_empty();
    tick(5);

    // Stalled DMI: FIFO fills after four commands; results return in order
    req_ready_en = 1'b0;
    addr_mode    = 1'b1;
    for (int i = 1; i <= 5; i++) sb.push_back({2'd0, 32'hA000_0000 | 32'(i)});
    for (int i = 1; i <= 4; i++) push_cmd(2'd1, 7'(i), 32'h0, pc);
    @(negedge clk);
    check("fifo_full", 32'(cmd_ready), 0);
    tick(1);
    fork
      push_cmd(2'd1, 7'd5, 32'h0, pc);
      begin
        repeat (4) @(negedge clk);
        check("fifo_still_full", 32'(cmd_ready), 0);
        @(posedge clk);
        #1;
        req_ready_en = 1'b1;
      end
    join
    wait_sb_empty();
    addr_mode = 1'b0;

    // Exit commands: no DMI traffic, later code overwrites
    r0 = req_count;
    push_cmd(2'd3, 7'h0, 32'h5, pc);
    tick(4);
    check("exit_code5", exit, 32'h0000_000B);
    check("exit_no_req", req_count - r0, 0);
    push_cmd(2'd3, 7'h0, 32'h8000_0007, pc);
    tick(4);
    check("exit_code7", exit, 32'h0000_000F);

    // Reset while waiting for a response
    resp_delay = 1000;
    r0 = req_count;
    push_cmd(2'd1, 7'h20, 32'h0, pc);
    wait_req(r0 + 1);
    tick(3);
    reset_n = 1'b0;
    #1;
    check("mid_rst_cmd_ready", 32'(cmd_ready), 0);
    check("mid_rst_res_valid", 32'(res_valid), 0);
    check("mid_rst_res_resp", 32'(res_resp), 0);
    check("mid_rst_res_data", res_data, 0);
    check("mid_rst_req_valid", 32'(debug_req_valid), 0);
    check("mid_rst_req_addr", 32'(debug_req_bits_addr), 0);
    check("mid_rst_req_op", 32'(debug_req_bits_op), 0);
    check("mid_rst_req_data", debug_req_bits_data, 0);
    check("mid_rst_resp_ready", 32'(debug_resp_ready), 0);
    check("mid_rst_exit", exit, 0);
    check("mid_rst_timeout_err", 32'(timeout_err), 0);
    tick(2);
    reset_n    = 1'b1;
    resp_delay = 1;
    tick(30);
    check("post_rst_idle_res", 32'(res_valid), 0);

    // Normal command after reset
    slave_data = 32'h1357_9BDF;
    sb.push_back({2'd0, 32'h1357_9BDF});
    push_cmd(2'd1, 7'h21, 32'h0, pc);
    wait_sb_empty();
    tick(5);
    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
